comparador_serial_id: RTL and testbench

- Bit-serial, MSB-first (left-to-right) magnitude comparator controller.
- Holds two WIDTH-bit operands in shift registers and feeds one bit pair per clock into a single left-to-right comparison cell.
- The cell carries a 2-bit state (m,n) from cycle to cycle.
- Provides a start/done handshake, optional early termination, abort, and a registered result.
- Replaces a WIDTH-cell combinational chain where area matters more than latency.

---
 rtl/comparador_serial_id.sv | 133 +++++++++++++
 tb/tb_comparador_serial_id.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparador_serial_id.sv
// Bit-serial MSB-first magnitude comparator: one bit pair per clock through a single
// left-to-right cell carrying (m,n), with start/done handshake, early exit and abort.
module comparador_serial_id #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1,
    parameter int unsigned CW         = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [CW-1:0]    bits_used
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic             m_q, m_d;
    logic             n_q, n_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    bits_q, bits_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic          m_nx, n_nx;
    logic [CW-1:0] cnt_inc;
    logic          finish;

    // (m,n): 11 equal so far, 10 A>B, 01 A<B; the unequal codes are absorbing.
    always_comb begin
        m_nx    = ~n_q | (m_q & (sa_q[WIDTH-1] | ~sb_q[WIDTH-1]));
        n_nx    = ~m_q | (n_q & (~sa_q[WIDTH-1] | sb_q[WIDTH-1]));
        cnt_inc = cnt_q + CW'(1);
        finish  = (cnt_inc == CW'(WIDTH)) || (EARLY_EXIT && !(m_nx && n_nx));
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        m_d     = m_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    m_d     = 1'b1;
                    n_d     = 1'b1;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Abort leaves the previous result untouched.
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    m_d   = m_nx;
                    n_d   = n_nx;
                    sa_d  = {sa_q[WIDTH-2:0], 1'b0};
                    sb_d  = {sb_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_inc;
                    if (finish) begin
                        state_d = StDone;
                        gt_d    = m_nx & ~n_nx;
                        lt_d    = ~m_nx & n_nx;
                        eq_d    = m_nx & n_nx;
                        bits_d  = cnt_inc;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            m_q     <= 1'b1;
            n_q     <= 1'b1;
            cnt_q   <= '0;
            bits_q  <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            m_q     <= m_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign gt        = gt_q;
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign bits_used = bits_q;

`ifndef SYNTHESIS
    mn_never_zero: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StRun) |-> (m_q || n_q));
    done_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        done |=> !done);
`endif

endmodule

// File: tb/tb_comparador_serial_id.sv
// Bench for comparador_serial_id: one instance per EARLY_EXIT value sharing the same
// stimulus, checked against a reference model of magnitude and first-differing-bit position.
module tb_comparador_serial_id;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [7:0] a, b;
    logic [1:0] busy_v, done_v, gt_v, lt_v, eq_v;
    logic [3:0] bu_v [2];

    always #5 clk = ~clk;

    comparador_serial_id #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a(a), .b(b),
        .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .lt(lt_v[0]), .eq(eq_v[0]),
        .bits_used(bu_v[0])
    );

    comparador_serial_id #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_early (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a(a), .b(b),
        .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .lt(lt_v[1]), .eq(eq_v[1]),
        .bits_used(bu_v[1])
    );

    int         tests_run = 0;
    int         fails = 0;
    int         got_cyc [2];
    int         got_pulses [2];
    logic [2:0] got_res [2];
    logic [3:0] got_bu [2];
    logic [2:0] last_res [2];
    logic [3:0] last_bu [2];

    // Bit pairs examined with early exit: position (1 = MSB) of the first differing bit.
    function automatic int first_diff(input logic [7:0] x, input logic [7:0] y);
        int d;
        d = int'(x ^ y);
        return (d == 0) ? 8 : 9 - $clog2(d + 1);
    endfunction

    function automatic int exp_bits(input int d, input logic [7:0] x, input logic [7:0] y);
        return (d == 1) ? first_diff(x, y) : 8;
    endfunction

    function automatic logic [2:0] exp_res(input logic [7:0] x, input logic [7:0] y);
        return {x > y, x < y, x == y};
    endfunction

    // Start is sampled at the posedge closing cycle 0; returns #1 into cycle 1.
    task automatic launch(input logic [7:0] aa, input logic [7:0] bb);
        @(negedge clk);
        a = aa; b = bb; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    task automatic wait_done(input int first_cyc);
        for (int d = 0; d < 2; d++) begin
            got_cyc[d] = -1; got_pulses[d] = 0; got_res[d] = '0; got_bu[d] = '0;
        end
        for (int cyc = first_cyc; cyc <= 20; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (done_v[d]) begin
                    got_pulses[d]++;
                    if (got_cyc[d] < 0) begin
                        got_cyc[d] = cyc;
                        got_res[d] = {gt_v[d], lt_v[d], eq_v[d]};
                        got_bu[d]  = bu_v[d];
                    end
                end
            end
            if (got_cyc[0] >= 0 && got_cyc[1] >= 0) break;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if ({busy_v[d], done_v[d], gt_v[d], lt_v[d], eq_v[d], bu_v[d]} !== 9'd0) begin
                fails++;
                $display("FAIL reset_state dut%0d: got %b required 0", d,
                         {busy_v[d], done_v[d], gt_v[d], lt_v[d], eq_v[d], bu_v[d]});
            end
            last_res[d] = '0; last_bu[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] va [5];
        logic [7:0] vb [5];
        va = '{8'hA5, 8'h80, 8'h12, 8'hFF, 8'h3C};
        vb = '{8'hA5, 8'h7F, 8'h13, 8'h00, 8'h3D};
        for (int i = 0; i < 5; i++) begin
            launch(va[i], vb[i]);
            wait_done(1);
            for (int d = 0; d < 2; d++) begin
                tests_run += 4;
                if (got_cyc[d] !== exp_bits(d, va[i], vb[i]) + 1) begin
                    fails++;
                    $display("FAIL dir_latency dut%0d %h/%h: got %0d required %0d", d, va[i],
                             vb[i], got_cyc[d], exp_bits(d, va[i], vb[i]) + 1);
                end
                if (got_res[d] !== exp_res(va[i], vb[i])) begin
                    fails++;
                    $display("FAIL dir_gt_lt_eq dut%0d %h/%h: got %b required %b", d, va[i],
                             vb[i], got_res[d], exp_res(va[i], vb[i]));
                end
                if (got_bu[d] !== 4'(exp_bits(d, va[i], vb[i]))) begin
                    fails++;
                    $display("FAIL dir_bits_used dut%0d %h/%h: got %0d required %0d", d,
                             va[i], vb[i], got_bu[d], exp_bits(d, va[i], vb[i]));
                end
                if (got_pulses[d] !== 1) begin
                    fails++;
                    $display("FAIL dir_done_pulses dut%0d: got %0d required 1", d,
                             got_pulses[d]);
                end
                last_res[d] = exp_res(va[i], vb[i]);
                last_bu[d]  = 4'(exp_bits(d, va[i], vb[i]));
            end
        end
    endtask

    // Second compare gets a start pulse with new operands while busy; it must be ignored.
    task automatic test_back_to_back();
        int extra [2];
        for (int rep = 0; rep < 2; rep++) begin
            launch(8'h40, 8'h20);
            if (rep == 1) begin
                start = 1'b1; a = 8'h00; b = 8'hFF;
            end
            wait_done(1);
            for (int d = 0; d < 2; d++) begin
                tests_run += 4;
                if (got_cyc[d] !== exp_bits(d, 8'h40, 8'h20) + 1) begin
                    fails++;
                    $display("FAIL b2b_latency dut%0d rep%0d: got %0d required %0d", d, rep,
                             got_cyc[d], exp_bits(d, 8'h40, 8'h20) + 1);
                end
                if (got_res[d] !== exp_res(8'h40, 8'h20)) begin
                    fails++;
                    $display("FAIL b2b_gt_lt_eq dut%0d rep%0d: got %b required %b", d, rep,
                             got_res[d], exp_res(8'h40, 8'h20));
                end
                if (got_bu[d] !== 4'(exp_bits(d, 8'h40, 8'h20))) begin
                    fails++;
                    $display("FAIL b2b_bits_used dut%0d rep%0d: got %0d required %0d", d, rep,
                             got_bu[d], exp_bits(d, 8'h40, 8'h20));
                end
                if (got_pulses[d] !== 1) begin
                    fails++;
                    $display("FAIL b2b_done_pulses dut%0d rep%0d: got %0d required 1", d, rep,
                             got_pulses[d]);
                end
                last_res[d] = exp_res(8'h40, 8'h20);
                last_bu[d]  = 4'(exp_bits(d, 8'h40, 8'h20));
            end
        end
        @(negedge clk);
        tests_run++;
        if (busy_v !== 2'b00) begin
            fails++;
            $display("FAIL b2b_idle_after_done: got busy=%b required 00", busy_v);
        end
        extra = '{0, 0};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (done_v[d]) extra[d]++;
        end
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (extra[d] !== 0) begin
                fails++;
                $display("FAIL b2b_no_extra_done dut%0d: got %0d pulses required 0", d,
                         extra[d]);
            end
        end
    endtask

    task automatic test_abort();
        int pulses [2];
        launch(8'h01, 8'h02);
        @(posedge clk);
        #1;
        tests_run++;
        if (busy_v !== 2'b11) begin
            fails++;
            $display("FAIL abort_busy_run: got %b required 11", busy_v);
        end
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests_run += 3;
            if (busy_v[d] !== 1'b0) begin
                fails++;
                $display("FAIL abort_busy_low dut%0d: got %b required 0", d, busy_v[d]);
            end
            if ({gt_v[d], lt_v[d], eq_v[d]} !== last_res[d]) begin
                fails++;
                $display("FAIL abort_result_held dut%0d: got %b required %b", d,
                         {gt_v[d], lt_v[d], eq_v[d]}, last_res[d]);
            end
            if (bu_v[d] !== last_bu[d]) begin
                fails++;
                $display("FAIL abort_bits_held dut%0d: got %0d required %0d", d, bu_v[d],
                         last_bu[d]);
            end
        end
        pulses = '{0, 0};
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (done_v[d]) pulses[d]++;
        end
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (pulses[d] !== 0) begin
                fails++;
                $display("FAIL abort_no_done dut%0d: got %0d pulses required 0", d, pulses[d]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        launch(8'h0F, 8'h0E);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if ({busy_v[d], done_v[d], gt_v[d], lt_v[d], eq_v[d], bu_v[d]} !== 9'd0) begin
                fails++;
                $display("FAIL midrun_reset dut%0d: got %b required 0", d,
                         {busy_v[d], done_v[d], gt_v[d], lt_v[d], eq_v[d], bu_v[d]});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        launch(8'hFF, 8'h00);
        wait_done(1);
        for (int d = 0; d < 2; d++) begin
            tests_run += 3;
            if (got_cyc[d] !== exp_bits(d, 8'hFF, 8'h00) + 1) begin
                fails++;
                $display("FAIL post_reset_latency dut%0d: got %0d required %0d", d,
                         got_cyc[d], exp_bits(d, 8'hFF, 8'h00) + 1);
            end
            if (got_res[d] !== 3'b100) begin
                fails++;
                $display("FAIL post_reset_gt dut%0d: got %b required 100", d, got_res[d]);
            end
            if (got_bu[d] !== 4'(exp_bits(d, 8'hFF, 8'h00))) begin
                fails++;
                $display("FAIL post_reset_bits dut%0d: got %0d required %0d", d, got_bu[d],
                         exp_bits(d, 8'hFF, 8'h00));
            end
            last_res[d] = 3'b100;
            last_bu[d]  = 4'(exp_bits(d, 8'hFF, 8'h00));
        end
    endtask

    task automatic test_random();
        logic [7:0] aa, bb;
        for (int i = 0; i < 1500; i++) begin
            aa = 8'($urandom);
            case (i % 8)
                0:       bb = aa;
                1:       bb = aa ^ (8'h01 << $urandom_range(7));
                default: bb = 8'($urandom);
            endcase
            launch(aa, bb);
            wait_done(1);
            for (int d = 0; d < 2; d++) begin
                tests_run += 4;
                if (got_cyc[d] !== exp_bits(d, aa, bb) + 1) begin
                    fails++;
                    $display("FAIL rnd_latency dut%0d %h/%h: got %0d required %0d", d, aa, bb,
                             got_cyc[d], exp_bits(d, aa, bb) + 1);
                end
                if (got_res[d] !== exp_res(aa, bb)) begin
                    fails++;
                    $display("FAIL rnd_gt_lt_eq dut%0d %h/%h: got %b required %b", d, aa, bb,
                             got_res[d], exp_res(aa, bb));
                end
                if (got_bu[d] !== 4'(exp_bits(d, aa, bb))) begin
                    fails++;
                    $display("FAIL rnd_bits_used dut%0d %h/%h: got %0d required %0d", d, aa,
                             bb, got_bu[d], exp_bits(d, aa, bb));
                end
                if (got_pulses[d] !== 1) begin
                    fails++;
                    $display("FAIL rnd_done_pulses dut%0d: got %0d required 1", d,
                             got_pulses[d]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
